// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file, optional write-through forwarding via REGFILE_BYPASS_EN
module regfile_2r1w #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          ZERO_REG = 1,
    parameter int          SP_IDX   = 31,
    parameter logic [31:0] SP_RST   = 32'h000003FF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              wr_zero
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_RST);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              w_zero;
    logic              r1_zero;
    logic              r2_zero;
    assign w_zero  = (ZERO_REG != 0) && (waddr == '0);
    assign r1_zero = (ZERO_REG != 0) && (raddr1 == '0);
    assign r2_zero = (ZERO_REG != 0) && (raddr2 == '0);
    // storage update: async reset, writes to the zero register are dropped and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == SP_IDX && !(ZERO_REG != 0 && SP_IDX == 0)) ? SP_VAL : '0;
            wr_zero <= 1'b0;
        end else begin
            if (we && !w_zero)
                regs[waddr] <= wdata;
            wr_zero <= we && w_zero;
        end
    end
`ifdef REGFILE_BYPASS_EN
    // combinational reads with same-cycle forwarding of the pending write
    always_comb begin
        rdata1 = r1_zero ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
        rdata2 = r2_zero ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
    end
`else
    // combinational reads of stored contents
    always_comb begin
        rdata1 = r1_zero ? '0 : regs[raddr1];
        rdata2 = r2_zero ? '0 : regs[raddr2];
    end
`endif
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: scoreboard bench for regfile_2r1w against an array reference model
module tb_regfile_2r1w;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        wr_zero;

    regfile_2r1w dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .wr_zero(wr_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ez;
    } exp_t;

    logic [31:0] model [32];
    logic        mwz;
    exp_t        q [$];
    event        chk;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[31] = 32'h3FF;
        mwz = 1'b0;
    endtask

    task automatic expect_now(input string n);
        exp_t e;
        e.name = n;
        e.e1 = ref_rd(raddr1);
        e.e2 = ref_rd(raddr2);
        e.ez = mwz;
        q.push_back(e);
        -> chk;
    endtask

    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input string n);
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
        #1 expect_now({n, "_pre"});
        @(posedge clk);
        if (w && wa != 5'd0) model[wa] = wd;
        mwz = w && (wa == 5'd0);
        #1 expect_now({n, "_post"});
    endtask

    // monitor: pop every pending expectation and compare with the live outputs
    initial begin
        exp_t e;
        forever begin
            @(chk);
            while (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (rdata1 !== e.e1 || rdata2 !== e.e2 || wr_zero !== e.ez) begin
                    miscompares++;
                    $display("FAIL %s: got rdata1=%h rdata2=%h wr_zero=%b, want %h %h %b (t=%0t)",
                             e.name, rdata1, rdata2, wr_zero, e.e1, e.e2, e.ez, $time);
                end
            end
        end
    end

    initial begin
        logic [4:0] wa;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd31; raddr2 = 5'd4;
        // asynchronous reset asserted mid-cycle, checked before any edge
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 expect_now("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'hFFFFFFFF, 5'(i), 5'(31 - i), "rst_dump");
        // basic write, both ports on the same register, then full dump
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "w5");
        for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), "w5_dump");
        // discarded write to register 0, flag lasts one cycle
        step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd5, "w0");
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "w0_after");
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd31, "w0_clear");
        // read during write to the same address
        step(1'b1, 5'd7, 32'hA5A5A5A5, 5'd1, 5'd2, "w7a");
        step(1'b1, 5'd7, 32'h5A5A5A5A, 5'd7, 5'd7, "w7b");
        // we=0 sweep must leave everything untouched
        for (int i = 1; i < 32; i++) step(1'b0, 5'(i), 32'hFFFFFFFF, 5'(i), 5'(32 - i), "hold");
        // reset coinciding with a write loses the write
        step(1'b1, 5'd3, 32'h11, 5'd3, 5'd3, "w3");
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'h22; raddr1 = 5'd3; raddr2 = 5'd31;
        #1 rst = 1'b1;
        model_reset();
        #1 expect_now("rst_w_pre");
        @(posedge clk);
        #1 expect_now("rst_w_post");
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, "r3_after_rst");
        // randomized traffic with bias towards reg 0 and read/write collisions
        for (int i = 0; i < 300; i++) begin
            wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(1'($urandom), wa, $urandom,
                 ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                 ($urandom_range(0, 2) == 0) ? wa : 5'($urandom), "rand");
        end
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
